zeroriscy_sys_slave: RTL and testbench



---
 rtl/zeroriscy_sys_pkg.sv | 35 +++
 rtl/zeroriscy_uart_tx.sv | 122 ++++++++++++
 rtl/zeroriscy_sys_slave.sv | 133 +++++++++++++
 tb/tb_zeroriscy_sys_slave.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zeroriscy_sys_pkg.sv
// Shared definitions for the zeroriscy system-region slave: register word
// offsets, UART status bit positions, serializer states and a byte-merge helper.
package zeroriscy_sys_pkg;

   // Word offsets, i.e. ss_addr[7:2]
   localparam logic [5:0] REG_MTIME_LO    = 6'h00;
   localparam logic [5:0] REG_MTIME_HI    = 6'h01;
   localparam logic [5:0] REG_MTIMECMP_LO = 6'h02;
   localparam logic [5:0] REG_MTIMECMP_HI = 6'h03;
   localparam logic [5:0] REG_UART_DATA   = 6'h04;
   localparam logic [5:0] REG_UART_STATUS = 6'h05;
   localparam logic [5:0] REG_TOHOST      = 6'h06;

   localparam int STAT_FULL_BIT  = 0;
   localparam int STAT_EMPTY_BIT = 1;
   localparam int STAT_BUSY_BIT  = 2;

   typedef enum logic [1:0] {
      SER_IDLE,
      SER_START,
      SER_DATA,
      SER_STOP
   } ser_state_e;

   function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  be);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/zeroriscy_uart_tx.sv
// UART 8N1 transmitter: FIFO_DEPTH-entry byte FIFO feeding a serializer that
// holds each symbol for CLKS_PER_BIT cycles. Used only with ZERORISCY_SYS_UART_EN.
module zeroriscy_uart_tx
   import zeroriscy_sys_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push_i,
   input  logic [7:0] data_i,
   output logic       full_o,
   output logic       empty_o,
   output logic       busy_o,
   output logic       tx_o
);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);

   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             push, pop;

   ser_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             baud_end;

   assign full_o   = (count_q == (AW+1)'(FIFO_DEPTH));
   assign empty_o  = (count_q == '0);
   assign push     = push_i & ~full_o;
   assign baud_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: FIFO storage is deliberately not reset; pointers and count alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SER_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
      end
   end

   // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      pop     = 1'b0;
      case (state_q)
         SER_IDLE: begin
            if (!empty_o) begin
               pop     = 1'b1;
               shreg_d = mem_q[rd_ptr_q];
               cnt_d   = '0;
               state_d = SER_START;
            end
         end
         SER_START: begin
            cnt_d = baud_end ? '0 : cnt_q + CNT_W'(1);
            if (baud_end) begin
               bit_d   = '0;
               state_d = SER_DATA;
            end
         end
         SER_DATA: begin
            cnt_d = baud_end ? '0 : cnt_q + CNT_W'(1);
            if (baud_end) begin
               shreg_d = {1'b0, shreg_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = SER_STOP;
            end
         end
         SER_STOP: begin
            cnt_d = baud_end ? '0 : cnt_q + CNT_W'(1);
            if (baud_end) state_d = SER_IDLE;
         end
         default: state_d = SER_IDLE;
      endcase
   end

   always_comb begin
      tx_o   = 1'b1;
      busy_o = (state_q != SER_IDLE);
      case (state_q)
         SER_START: tx_o = 1'b0;
         SER_DATA:  tx_o = shreg_q[0];
         default:   tx_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/zeroriscy_sys_slave.sv
// System-region slave: 64-bit machine timer + compare IRQ, UART TX, tohost.
// The UART FIFO/serializer exists only when ZERORISCY_SYS_UART_EN is defined.
module zeroriscy_sys_slave
   import zeroriscy_sys_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ss_req,
   input  logic        ss_we,
   input  logic [3:0]  ss_be,
   input  logic [31:0] ss_addr,
   input  logic [31:0] ss_wdata,
   output logic [31:0] ss_rdata,
   output logic        ss_gnt,
   output logic        ss_rvalid,
   output logic        ss_err,
   output logic        timer_irq,
   output logic        uart_tx,
   output logic        tohost_valid,
   output logic [31:0] tohost_data
);
   logic [5:0]  word;
   logic        wr, hit, tohost_wr, uart_push;
   logic        uart_full, uart_empty, uart_busy;
   logic [31:0] rd_val, status;
   logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
   logic [31:0] rdata_q, tohost_q;
   logic        rvalid_q, err_q, irq_q, tohost_valid_q;
   logic        unused_addr;

   assign word        = ss_addr[7:2];
   assign unused_addr = ^{ss_addr[31:8], ss_addr[1:0]};

   // Only a UART_DATA write against a full FIFO (registered count) is held off
   assign ss_gnt    = ss_req & ~(ss_we & (word == REG_UART_DATA) & uart_full);
   assign wr        = ss_gnt & ss_we;
   assign tohost_wr = wr & (word == REG_TOHOST);
   assign uart_push = wr & (word == REG_UART_DATA) & ss_be[0];

   always_comb begin
      status                 = '0;
      status[STAT_FULL_BIT]  = uart_full;
      status[STAT_EMPTY_BIT] = uart_empty;
      status[STAT_BUSY_BIT]  = uart_busy;
   end

   always_comb begin
      hit    = 1'b1;
      rd_val = '0;
      case (word)
         REG_MTIME_LO:    rd_val = mtime_q[31:0];
         REG_MTIME_HI:    rd_val = mtime_q[63:32];
         REG_MTIMECMP_LO: rd_val = mtimecmp_q[31:0];
         REG_MTIMECMP_HI: rd_val = mtimecmp_q[63:32];
         REG_UART_DATA:   rd_val = '0;
         REG_UART_STATUS: rd_val = status;
         REG_TOHOST:      rd_val = tohost_q;
         default:         hit    = 1'b0;
      endcase
   end

   // A write to either mtime half freezes the counter for that cycle (no carry)
   always_comb begin
      mtime_d    = mtime_q + 64'd1;
      mtimecmp_d = mtimecmp_q;
      if (wr && word == REG_MTIME_LO)
         mtime_d = {mtime_q[63:32], be_merge(mtime_q[31:0], ss_wdata, ss_be)};
      else if (wr && word == REG_MTIME_HI)
         mtime_d = {be_merge(mtime_q[63:32], ss_wdata, ss_be), mtime_q[31:0]};
      if (wr && word == REG_MTIMECMP_LO)
         mtimecmp_d[31:0] = be_merge(mtimecmp_q[31:0], ss_wdata, ss_be);
      if (wr && word == REG_MTIMECMP_HI)
         mtimecmp_d[63:32] = be_merge(mtimecmp_q[63:32], ss_wdata, ss_be);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mtime_q        <= '0;
         mtimecmp_q     <= '1;
         rdata_q        <= '0;
         rvalid_q       <= 1'b0;
         err_q          <= 1'b0;
         irq_q          <= 1'b0;
         tohost_q       <= '0;
         tohost_valid_q <= 1'b0;
      end else begin
         mtime_q        <= mtime_d;
         mtimecmp_q     <= mtimecmp_d;
         rvalid_q       <= ss_gnt;
         err_q          <= ss_gnt & ~hit;
         rdata_q        <= (ss_gnt && !ss_we && hit) ? rd_val : '0;
         irq_q          <= (mtime_q >= mtimecmp_q);
         tohost_valid_q <= tohost_wr;
         if (tohost_wr) tohost_q <= ss_wdata;
      end
   end

   assign ss_rdata     = rdata_q;
   assign ss_rvalid    = rvalid_q;
   assign ss_err       = err_q;
   assign timer_irq    = irq_q;
   assign tohost_valid = tohost_valid_q;
   assign tohost_data  = tohost_q;

`ifdef ZERORISCY_SYS_UART_EN
   zeroriscy_uart_tx #(
      .FIFO_DEPTH   (FIFO_DEPTH),
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart_tx (
      .clk     (clk),
      .reset   (reset),
      .push_i  (uart_push),
      .data_i  (ss_wdata[7:0]),
      .full_o  (uart_full),
      .empty_o (uart_empty),
      .busy_o  (uart_busy),
      .tx_o    (uart_tx)
   );
`else
   logic        unused_push;
   logic [31:0] unused_cfg;
   assign unused_push = uart_push;
   assign unused_cfg  = FIFO_DEPTH + CLKS_PER_BIT;
   assign uart_full   = 1'b0;
   assign uart_empty  = 1'b1;
   assign uart_busy   = 1'b0;
   assign uart_tx     = 1'b1;
`endif

endmodule

// File: tb/tb_zeroriscy_sys_slave.sv
// Scoreboard bench for zeroriscy_sys_slave: responses are queued at grant time
// and popped by an independent monitor; a line receiver collects UART bytes.
module tb_zeroriscy_sys_slave;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        ss_req, ss_we;
   logic [3:0]  ss_be;
   logic [31:0] ss_addr, ss_wdata;
   logic [31:0] ss_rdata;
   logic        ss_gnt, ss_rvalid, ss_err;
   logic        timer_irq, uart_tx, tohost_valid;
   logic [31:0] tohost_data;

   zeroriscy_sys_slave #(.FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
      .clk          (clk),
      .reset        (reset),
      .ss_req       (ss_req),
      .ss_we        (ss_we),
      .ss_be        (ss_be),
      .ss_addr      (ss_addr),
      .ss_wdata     (ss_wdata),
      .ss_rdata     (ss_rdata),
      .ss_gnt       (ss_gnt),
      .ss_rvalid    (ss_rvalid),
      .ss_err       (ss_err),
      .timer_irq    (timer_irq),
      .uart_tx      (uart_tx),
      .tohost_valid (tohost_valid),
      .tohost_data  (tohost_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic [31:0] mask;
      logic        err;
      longint      due;
      string       name;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [7:0]  rx[$];
   int          n_vec = 0;
   int          n_bad = 0;
   longint      cnt = 0;
   longint      last_acc;
   logic [63:0] mt, cmp;

   always @(posedge clk) cnt <= cnt + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every rvalid must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (ss_rvalid) begin
         if (sb.size() == 0) begin
            check("unexpected_rvalid", 64'd1, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check({mon_e.name, "_cycle"}, cnt, mon_e.due);
            check({mon_e.name, "_err"}, {63'd0, ss_err}, {63'd0, mon_e.err});
            check({mon_e.name, "_rdata"}, {32'd0, ss_rdata & mon_e.mask}, {32'd0, mon_e.rdata & mon_e.mask});
         end
      end
   end

   // Line receiver: samples mid-bit, 8N1
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (!reset && uart_tx === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = uart_tx;
            end
            repeat (CPB) @(negedge clk);
            rx.push_back(b);
         end
      end
   end

   function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? n[8*i +: 8] : o[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] addr);
      case (addr[7:2])
         6'h0:    return mt[31:0];
         6'h1:    return mt[63:32];
         6'h2:    return cmp[31:0];
         6'h3:    return cmp[63:32];
         default: return 32'd0;
      endcase
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         mt = mt + 64'd1;
         @(negedge clk);
      end
   endtask

   task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input logic use_model, input logic [31:0] exp_rd,
                         input logic [31:0] mask, input logic exp_err, input string name);
      logic [31:0] e;
      ss_req = 1'b1; ss_we = we; ss_addr = addr; ss_be = be; ss_wdata = wdata;
      #1;
      for (int i = 0; i < 500 && !ss_gnt; i++) begin
         mt = mt + 64'd1;
         @(negedge clk);
         #1;
      end
      if (!ss_gnt) begin
         check({name, "_gnt_timeout"}, 64'd0, 64'd1);
         ss_req = 1'b0;
         last_acc = -1;
         return;
      end
      last_acc = cnt;
      e = use_model ? model_read(addr) : exp_rd;
      sb.push_back('{e, mask, exp_err, cnt + 1, name});
      if (we && addr[7:2] == 6'h0)      mt = {mt[63:32], bmerge(mt[31:0], wdata, be)};
      else if (we && addr[7:2] == 6'h1) mt = {bmerge(mt[63:32], wdata, be), mt[31:0]};
      else                              mt = mt + 64'd1;
      if (we && addr[7:2] == 6'h2) cmp[31:0]  = bmerge(cmp[31:0], wdata, be);
      if (we && addr[7:2] == 6'h3) cmp[63:32] = bmerge(cmp[63:32], wdata, be);
      @(negedge clk);
      ss_req = 1'b0; ss_we = 1'b0;
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
      access(1'b0, addr, 4'hF, 32'd0, 1'b0, exp, 32'hFFFF_FFFF, 1'b0, name);
   endtask

   task automatic rdm(input logic [31:0] addr, input string name);
      access(1'b0, addr, 4'hF, 32'd0, 1'b1, 32'd0, 32'hFFFF_FFFF, 1'b0, name);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] d,
                     input logic err, input string name);
      access(1'b1, addr, be, d, 1'b0, 32'd0, 32'd0, err, name);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion, expected bench end");
      $fatal(1, "bench timeout");
   end

   initial begin
      longint     w, acc[6];
      logic [9:0] frame;
      logic [7:0] bytes[7];
      int         bad_tx;

      reset = 1'b1; ss_req = 1'b0; ss_we = 1'b0; ss_be = '0; ss_addr = '0; ss_wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_rdata", {32'd0, ss_rdata}, 64'd0);
      check("rst_rvalid", {63'd0, ss_rvalid}, 64'd0);
      check("rst_err", {63'd0, ss_err}, 64'd0);
      check("rst_irq", {63'd0, timer_irq}, 64'd0);
      check("rst_tx", {63'd0, uart_tx}, 64'd1);
      check("rst_tohost_valid", {63'd0, tohost_valid}, 64'd0);
      check("rst_tohost_data", {32'd0, tohost_data}, 64'd0);
      reset = 1'b0;
      mt  = 64'd0;
      cmp = '1;

      // mtime counts one per cycle; first read right after reset sees 0
      rd(32'h00, 32'd0, "mtime_lo_first");
      idle(9);
      rd(32'h00, 32'd10, "mtime_lo_plus10");
      rd(32'h08, 32'hFFFF_FFFF, "cmp_lo_rst");
      rd(32'h0C, 32'hFFFF_FFFF, "cmp_hi_rst");

      // Compare interrupt
      wr(32'h0C, 4'hF, 32'd0, 1'b0, "wr_cmp_hi0");
      wr(32'h08, 4'hF, mt[31:0] + 32'd20, 1'b0, "wr_cmp_lo");
      w = last_acc;
      for (int j = 0; j < 24; j++) begin
         check("irq_rise", {63'd0, timer_irq}, {63'd0, (cnt >= w + 21)});
         idle(1);
      end
      wr(32'h0C, 4'hF, 32'hFFFF_FFFF, 1'b0, "wr_cmp_hi1");
      check("irq_hold", {63'd0, timer_irq}, 64'd1);
      idle(1);
      check("irq_fall", {63'd0, timer_irq}, 64'd0);

      // Byte-enable writes
      wr(32'h08, 4'b0101, 32'h1122_3344, 1'b0, "wr_cmp_lo_be");
      rdm(32'h08, "cmp_lo_be");
      wr(32'h04, 4'b0010, 32'h0000_AB00, 1'b0, "wr_mtime_hi_be");
      rdm(32'h04, "mtime_hi_be");

      // Low-half wrap carries into the high half
      wr(32'h00, 4'hF, 32'hFFFF_FFFF, 1'b0, "wr_mtime_lo");
      wr(32'h04, 4'hF, 32'd0, 1'b0, "wr_mtime_hi");
      rd(32'h04, 32'd0, "mtime_hi_prewrap");
      rd(32'h04, 32'd1, "mtime_hi_wrap");
      rdm(32'h00, "mtime_lo_wrap");

      // Unmapped offsets and tohost
      access(1'b0, 32'h40, 4'hF, 32'd0, 1'b0, 32'd0, 32'hFFFF_FFFF, 1'b1, "rd_unmapped");
      wr(32'h18, 4'b0001, 32'd1, 1'b0, "wr_tohost");
      check("tohost_pulse", {63'd0, tohost_valid}, 64'd1);
      check("tohost_data", {32'd0, tohost_data}, 64'd1);
      idle(1);
      check("tohost_pulse_end", {63'd0, tohost_valid}, 64'd0);
      wr(32'h44, 4'hF, 32'hDEAD_BEEF, 1'b1, "wr_unmapped");
      rd(32'hF000_001B, 32'd1, "rd_tohost_alias");
      rd(32'h10, 32'd0, "rd_uart_data");
      wr(32'h14, 4'hF, 32'hFFFF_FFFF, 1'b0, "wr_status");
      wr(32'h10, 4'b1110, 32'h0000_00AA, 1'b0, "wr_uart_nobe0");
      rd(32'h14, 32'h2, "status_idle");

`ifdef ZERORISCY_SYS_UART_EN
      frame = {1'b1, 8'h55, 1'b0};
      wr(32'h10, 4'h1, 32'h55, 1'b0, "wr_uart_55");
      check("tx_before_start", {63'd0, uart_tx}, 64'd1);
      idle(1);
      for (int k = 0; k < 10 * CPB; k++) begin
         check("tx_frame_55", {63'd0, uart_tx}, {63'd0, frame[k / CPB]});
         if (k == 5 * CPB) rd(32'h14, 32'h6, "status_busy");
         else idle(1);
      end
      rd(32'h14, 32'h2, "status_done");

      // Overfill: DEPTH+2 writes, the last waits for the second pop
      bytes[0] = 8'h55;
      for (int i = 0; i < 6; i++) begin
         bytes[i+1] = 8'hA0 + 8'(i * 3);
         wr(32'h10, 4'h1, {24'd0, bytes[i+1]}, 1'b0, "wr_uart_burst");
         acc[i] = last_acc;
      end
      for (int i = 1; i < 5; i++) check("burst_accept", acc[i] - acc[0], i);
      check("burst_stall_release", acc[5] - acc[0], 10 * CPB + 3);
      for (int i = 0; i < 5000 && rx.size() < 7; i++) idle(1);
      check("rx_count", rx.size(), 7);
      for (int i = 0; i < 7; i++) begin
         if (i < rx.size()) check("rx_byte", {56'd0, rx[i]}, {56'd0, bytes[i]});
      end

      // Reset mid-frame with a request in flight
      wr(32'h10, 4'h1, 32'h0F, 1'b0, "wr_uart_pre_reset");
      idle(10);
`else
      for (int i = 0; i < 6; i++) begin
         wr(32'h10, 4'h1, 32'hA0 + i, 1'b0, "wr_uart_off");
         acc[i] = last_acc;
      end
      check("uart_off_no_stall", acc[5] - acc[0], 5);
      bad_tx = 0;
      for (int k = 0; k < 50; k++) begin
         if (uart_tx !== 1'b1) bad_tx++;
         idle(1);
      end
      check("uart_off_tx_idle", bad_tx, 0);
      rd(32'h14, 32'h2, "status_off");
`endif
      ss_req = 1'b1; ss_we = 1'b0; ss_addr = 32'h18; ss_be = 4'hF;
      reset = 1'b1;
      @(negedge clk);
      check("rst2_rvalid", {63'd0, ss_rvalid}, 64'd0);
      check("rst2_tx", {63'd0, uart_tx}, 64'd1);
      check("rst2_tohost", {32'd0, tohost_data}, 64'd0);
      check("rst2_irq", {63'd0, timer_irq}, 64'd0);
      reset = 1'b0; ss_req = 1'b0;
      mt  = 64'd0;
      cmp = '1;
      rd(32'h14, 32'h2, "status_after_reset");
      rd(32'h00, 32'd1, "mtime_after_reset");
      idle(3);
      check("sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
